dispatch_queue: RTL and testbench
=================================

Name: dispatch_queue

Overview:
- Parametrised, WIDTH-wide in-order instruction buffer between fetch (IF_ID_PACKET) and the dispatch decoders.
- Absorbs fetch bursts in a DEPTH-entry circular queue.
- Each cycle, releases the oldest instructions that fit the available ROB, RS and free-list resources, with strict in-order cut-off.
- Adds squash flush, halt blocking and a dispatch performance counter.

Parameters:
- WIDTH, 3, fetch and dispatch slots per cycle (>=1).
- DEPTH, 8, queue entries; power of two, DEPTH >= WIDTH.
- CNT_W, $clog2(WIDTH+1), width of all per-cycle slot counts.

Ports:
- clock  in  1  single clock; all state updates on posedge.
- reset  in  1  synchronous, active-high.
- squash  in  1  synchronous flush (mispredict / exception).
- if_packet_in  in  WIDTH x IF_ID_PACKET  fetched group; slot 0 is oldest.
- enq_ready_cnt  out  CNT_W  number of fetch slots accepted this cycle = min(WIDTH, DEPTH-count); combinational from registered count.
- dis_packet  out  WIDTH x IF_ID_PACKET  head entries; slot i = entry head+i mod DEPTH.
- needs_pr  in  WIDTH  from downstream decoders: slot i allocates a PR (dest != ZERO_REG).
- rob_free  in  CNT_W  ROB entries available this cycle, saturated to WIDTH by the source.
- rs_free  in  CNT_W  RS entries available, saturated to WIDTH.
- pr_free  in  CNT_W  free PRs available, saturated to WIDTH.
- dis_valid  out  WIDTH  slot i dispatches this cycle.
- d_stall  out  WIDTH  slot i is occupied but held.
- dispatch_cnt  out  CNT_W  number of dis_valid bits set.
- halted  out  1  registered; a WFI has been dispatched.
- dispatched_total  out  32  registered count of dispatched instructions; wraps.

Behaviour:
State:
- Entries storage; head and tail, each $clog2(DEPTH) bits, wrapping mod DEPTH.
- count, 0..DEPTH; halted flag; dispatched_total.

Reset (and squash) effects:
- reset: head=tail=count=0, halted=0, dispatched_total=0.
- Outputs under reset: dis_valid=0, d_stall=0, dispatch_cnt=0, enq_ready_cnt=WIDTH.
- squash: same as reset, except dispatched_total is kept.
- During a squash cycle: enqueue is ignored and dis_valid/dispatch_cnt are forced to 0.
- reset has priority over squash.

Enqueue:
- Accepted = min(leading contiguous run of valid slots in if_packet_in, enq_ready_cnt).
- Slots after the first invalid slot are dropped.
- Accepted slots are written at tail, tail+1, … in slot order.
- tail advances by the accepted count.
- Space is based on the start-of-cycle count; same-cycle dequeue does not add space.

Dispatch (combinational from registered state plus the free inputs):
- occ[i] = (i < count) & ~halted.
- dis_packet[i].valid = occ[i].
- dispatch_cnt = largest k <= min(count, WIDTH) such that all of the following hold:
  - k <= rob_free;
  - k <= rs_free;
  - sum of needs_pr[0..k-1] <= pr_free;
  - no WFI (inst == 32'h10500073) in slots 0..k-2. A WFI may itself dispatch, but nothing younger dispatches in the same cycle.
- dis_valid[i] = (i < dispatch_cnt).
- d_stall[i] = occ[i] & ~dis_valid[i].
- Once an older slot stalls, no younger slot dispatches (in-order cut-off).

Sequential update:
- head advances by dispatch_cnt.
- count_next = count + accepted - dispatch_cnt; never exceeds DEPTH, never underflows.
- dispatched_total increments by dispatch_cnt.
- halted sets when a dispatched slot holds a WFI.
- While halted: dispatch is blocked, but enqueue continues until the queue is full.

Boundary cases:
- count=0: all occ=0; dispatch_cnt=0.
- count=DEPTH: enq_ready_cnt=0.
- Pointer wrap: a group may straddle entry DEPTH-1 to entry 0, on both enqueue and dispatch.
- Simultaneous enqueue and dispatch is legal in every state.

Test Plan:
- Reset, then 3 valid packets at PCs 0x0/0x4/0x8 with all free counts =3 and needs_pr=111 → next cycle dis_valid=111, dispatch_cnt=3, count returns to 0, dispatched_total=3.
- Fill: hold all free counts at 0 and push 3 packets per cycle → enq_ready_cnt goes 3,3,2,0; count=8; d_stall=111; accepted PCs stay in order.
- pr_free=1 with needs_pr=101 and rob_free=rs_free=3 → dispatch_cnt=2 (slot 1 has no dest); next cycle slot 0 holds the former slot 2.
- Valid pattern 101 from fetch → only slot 0 accepted; count increases by 1.
- WFI in slot 1 of a 3-entry head group, all free counts =3 → dis_valid=011; halted=1 next cycle; later dis_valid=000 while count>0.
- Squash asserted with count=6 and a fetch group present → that cycle dis_valid=000; next cycle count=0, halted=0, dispatched_total unchanged. Then exercise wrap from head=7: two entries dispatch from indices 7 and 0 correctly.

Source files
------------

// File: rtl/dispatch_queue.sv
// In-order dispatch buffer between fetch and the decoders: a DEPTH-entry circular queue that
// releases the oldest WIDTH entries as far as ROB/RS/free-list room and WFI halting allow.
module dispatch_queue #(
    parameter int unsigned WIDTH = 3,
    parameter int unsigned DEPTH = 8,
    parameter int unsigned CNT_W = $clog2(WIDTH + 1),
    // Packet layout: [PKT_W-1] valid, [PKT_W-2 -: 32] inst, [31:0] pc; PKT_W >= 65.
    parameter int unsigned PKT_W = 65
) (
    input  logic                        clock,
    input  logic                        reset,
    input  logic                        squash,
    input  logic [WIDTH-1:0][PKT_W-1:0] if_packet_in,
    output logic [CNT_W-1:0]            enq_ready_cnt,
    output logic [WIDTH-1:0][PKT_W-1:0] dis_packet,
    input  logic [WIDTH-1:0]            needs_pr,
    input  logic [CNT_W-1:0]            rob_free,
    input  logic [CNT_W-1:0]            rs_free,
    input  logic [CNT_W-1:0]            pr_free,
    output logic [WIDTH-1:0]            dis_valid,
    output logic [WIDTH-1:0]            d_stall,
    output logic [CNT_W-1:0]            dispatch_cnt,
    output logic                        halted,
    output logic [31:0]                 dispatched_total
);

    localparam int unsigned PTR_W = $clog2(DEPTH);
    localparam logic [31:0] WFI_INST = 32'h10500073;

    logic [PKT_W-1:0] mem_q [DEPTH];
    logic [PTR_W-1:0] head_q, head_d;
    logic [PTR_W-1:0] tail_q, tail_d;
    logic [PTR_W:0]   count_q, count_d;
    logic             halted_q, halted_d;
    logic [31:0]      total_q, total_d;

    logic [CNT_W-1:0] acc_cnt;
    logic [CNT_W-1:0] disp_cnt;
    logic [WIDTH-1:0] occ;
    logic             wfi_disp;

    // Enqueue: leading run of valid fetch slots, clipped to start-of-cycle free space.
    always_comb begin
        int unsigned space;
        int unsigned room;
        int unsigned run;
        int unsigned acc;
        logic        run_on;
        space  = DEPTH - 32'(count_q);
        room   = (space < WIDTH) ? space : WIDTH;
        run    = 0;
        run_on = 1'b1;
        for (int unsigned i = 0; i < WIDTH; i++) begin
            if (run_on && if_packet_in[i][PKT_W-1]) begin
                run = run + 1;
            end else begin
                run_on = 1'b0;
            end
        end
        acc           = (run < room) ? run : room;
        enq_ready_cnt = reset ? CNT_W'(WIDTH) : CNT_W'(room);
        acc_cnt       = (reset || squash) ? '0 : CNT_W'(acc);
    end

    // Dispatch: walk head slots oldest-first; the first slot that fails any resource check,
    // or the slot after a WFI, ends the group.
    always_comb begin
        int unsigned      pr_sum;
        int unsigned      disp;
        logic             go;
        logic [PKT_W-1:0] ent;
        pr_sum     = 0;
        disp       = 0;
        go         = ~reset & ~squash & ~halted_q;
        wfi_disp   = 1'b0;
        occ        = '0;
        dis_packet = '0;
        for (int unsigned i = 0; i < WIDTH; i++) begin
            ent    = mem_q[PTR_W'(32'(head_q) + i)];
            occ[i] = (i < 32'(count_q)) && !halted_q && !reset;
            dis_packet[i]          = ent;
            dis_packet[i][PKT_W-1] = occ[i];
            pr_sum = pr_sum + 32'(needs_pr[i]);
            if (go && occ[i] && (i < 32'(rob_free)) && (i < 32'(rs_free)) &&
                (pr_sum <= 32'(pr_free))) begin
                disp = i + 1;
                if (ent[PKT_W-2 -: 32] == WFI_INST) begin
                    wfi_disp = 1'b1;
                    go       = 1'b0;
                end
            end else begin
                go = 1'b0;
            end
        end
        disp_cnt     = CNT_W'(disp);
        dispatch_cnt = disp_cnt;
        for (int unsigned i = 0; i < WIDTH; i++) begin
            dis_valid[i] = (i < disp);
        end
        d_stall = occ & ~dis_valid;
    end

    always_comb begin
        head_d   = PTR_W'(32'(head_q) + 32'(disp_cnt));
        tail_d   = PTR_W'(32'(tail_q) + 32'(acc_cnt));
        count_d  = (PTR_W + 1)'(32'(count_q) + 32'(acc_cnt) - 32'(disp_cnt));
        halted_d = halted_q | wfi_disp;
        total_d  = total_q + 32'(disp_cnt);
        if (squash) begin
            head_d   = '0;
            tail_d   = '0;
            count_d  = '0;
            halted_d = 1'b0;
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            head_q   <= '0;
            tail_q   <= '0;
            count_q  <= '0;
            halted_q <= 1'b0;
            total_q  <= '0;
        end else begin
            head_q   <= head_d;
            tail_q   <= tail_d;
            count_q  <= count_d;
            halted_q <= halted_d;
            total_q  <= total_d;
        end
    end

    always_ff @(posedge clock) begin
        for (int unsigned i = 0; i < WIDTH; i++) begin
            if (i < 32'(acc_cnt)) begin
                mem_q[PTR_W'(32'(tail_q) + i)] <= if_packet_in[i];
            end
        end
    end

    assign halted           = halted_q;
    assign dispatched_total = total_q;

endmodule

// File: tb/tb_dispatch_queue.sv
// Directed bench for dispatch_queue: a reference queue of fetched PCs is filled on acceptance
// and drained as slots dispatch, with per-cycle checks of counts, masks and packet contents.
module tb_dispatch_queue;

    localparam int unsigned W  = 3;
    localparam int unsigned D  = 8;
    localparam int unsigned CW = 2;
    localparam int unsigned PW = 65;
    localparam logic [31:0] WFI = 32'h10500073;
    localparam logic [31:0] NOP = 32'h00000013;

    logic                   clock = 1'b0;
    logic                   reset;
    logic                   squash;
    logic [W-1:0][PW-1:0]   if_packet_in;
    logic [CW-1:0]          enq_ready_cnt;
    logic [W-1:0][PW-1:0]   dis_packet;
    logic [W-1:0]           needs_pr;
    logic [CW-1:0]          rob_free;
    logic [CW-1:0]          rs_free;
    logic [CW-1:0]          pr_free;
    logic [W-1:0]           dis_valid;
    logic [W-1:0]           d_stall;
    logic [CW-1:0]          dispatch_cnt;
    logic                   halted;
    logic [31:0]            dispatched_total;

    dispatch_queue #(.WIDTH(W), .DEPTH(D), .CNT_W(CW), .PKT_W(PW)) dut (
        .clock            (clock),
        .reset            (reset),
        .squash           (squash),
        .if_packet_in     (if_packet_in),
        .enq_ready_cnt    (enq_ready_cnt),
        .dis_packet       (dis_packet),
        .needs_pr         (needs_pr),
        .rob_free         (rob_free),
        .rs_free          (rs_free),
        .pr_free          (pr_free),
        .dis_valid        (dis_valid),
        .d_stall          (d_stall),
        .dispatch_cnt     (dispatch_cnt),
        .halted           (halted),
        .dispatched_total (dispatched_total)
    );

    always #5 clock = ~clock;

    typedef struct packed {
        logic [31:0] pc;
        logic        wfi;
    } sb_t;

    sb_t         sb[$];
    int          compared   = 0;
    int          mismatched = 0;
    int          mcount     = 0;
    int          mtotal     = 0;
    logic        mhalted    = 1'b0;
    logic [2:0]  fv;
    logic [2:0]  fwfi;
    logic [31:0] fbase;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        compared++;
        assert (obs === exp) else begin
            mismatched++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic set_fetch(input logic [2:0] v, input logic [31:0] base, input logic [2:0] wfi);
        fv    = v;
        fwfi  = wfi;
        fbase = base;
        for (int i = 0; i < 3; i++) begin
            if_packet_in[i] = {v[i], (wfi[i] ? WFI : NOP), base + 32'(4 * i)};
        end
    endtask

    task automatic set_free(input logic [1:0] rob, input logic [1:0] rs, input logic [1:0] pr,
                            input logic [2:0] npr);
        rob_free = rob;
        rs_free  = rs;
        pr_free  = pr;
        needs_pr = npr;
    endtask

    // One clock: inputs already driven; exp is the directed dispatch count for this cycle.
    task automatic cycle(input int exp, input string tag);
        int         room;
        int         occn;
        int         run;
        int         acc;
        logic       hnext;
        logic [2:0] disv;
        logic [2:0] occm;
        logic [2:0] vbits;
        sb_t        e;
        #1;
        room  = (D - mcount < W) ? D - mcount : W;
        occn  = mhalted ? 0 : ((mcount < 3) ? mcount : 3);
        disv  = 3'((1 << exp) - 1);
        occm  = 3'((1 << occn) - 1);
        vbits = {dis_packet[2][PW-1], dis_packet[1][PW-1], dis_packet[0][PW-1]};
        hnext = mhalted;
        chk({tag, ":halted"}, 32'(halted), 32'(mhalted));
        chk({tag, ":total"}, dispatched_total, 32'(mtotal));
        chk({tag, ":enq_ready"}, 32'(enq_ready_cnt), 32'(room));
        chk({tag, ":dispatch_cnt"}, 32'(dispatch_cnt), 32'(exp));
        chk({tag, ":dis_valid"}, 32'(dis_valid), 32'(disv));
        chk({tag, ":d_stall"}, 32'(d_stall), 32'(occm & ~disv));
        chk({tag, ":pkt_valid"}, 32'(vbits), 32'(occm));
        for (int i = 0; i < exp; i++) begin
            if (sb.size() == 0) begin
                chk($sformatf("%s:sb_empty%0d", tag, i), 32'(dis_valid[i]), 32'd0);
            end else begin
                e = sb.pop_front();
                if (e.wfi) hnext = 1'b1;
                chk($sformatf("%s:disp_pc%0d", tag, i), dis_packet[i][31:0], e.pc);
            end
        end
        for (int i = exp; i < occn; i++) begin
            if (i - exp < sb.size()) begin
                chk($sformatf("%s:held_pc%0d", tag, i), dis_packet[i][31:0], sb[i - exp].pc);
            end
        end
        if (squash) begin
            sb.delete();
            mcount = 0;
            hnext  = 1'b0;
        end else begin
            run = 0;
            while (run < 3 && fv[run]) run++;
            acc = (run < room) ? run : room;
            for (int i = 0; i < acc; i++) begin
                sb.push_back('{pc: fbase + 32'(4 * i), wfi: fwfi[i]});
            end
            mcount = mcount + acc - exp;
        end
        mtotal  = mtotal + exp;
        mhalted = hnext;
        @(posedge clock);
        #1;
    endtask

    initial begin
        reset  = 1'b1;
        squash = 1'b0;
        set_fetch(3'b000, 32'h0, 3'b000);
        set_free(2'd3, 2'd3, 2'd3, 3'b111);
        @(posedge clock);
        #1;
        chk("rst:enq_ready", 32'(enq_ready_cnt), 32'd3);
        chk("rst:dis_valid", 32'(dis_valid), 32'd0);
        chk("rst:d_stall", 32'(d_stall), 32'd0);
        chk("rst:dispatch_cnt", 32'(dispatch_cnt), 32'd0);
        @(posedge clock);
        #1;
        chk("rst:halted", 32'(halted), 32'd0);
        chk("rst:total", dispatched_total, 32'd0);
        reset = 1'b0;

        // Basic enqueue then full-width dispatch
        set_fetch(3'b111, 32'h0, 3'b000);   cycle(0, "t1_enq");
        set_fetch(3'b000, 32'h0, 3'b000);   cycle(3, "t1_disp");
        cycle(0, "t1_idle");

        // Fill with no downstream room; group wraps through entry 7 -> 0
        set_free(2'd0, 2'd0, 2'd0, 3'b111);
        set_fetch(3'b111, 32'h100, 3'b000); cycle(0, "fill0");
        set_fetch(3'b111, 32'h10C, 3'b000); cycle(0, "fill1");
        set_fetch(3'b111, 32'h118, 3'b000); cycle(0, "fill2");
        set_fetch(3'b111, 32'h200, 3'b000); cycle(0, "fill3");
        set_fetch(3'b000, 32'h0, 3'b000);   cycle(0, "full");

        // Free-PR limit with slot 1 not needing a PR
        set_free(2'd3, 2'd3, 2'd1, 3'b101); cycle(2, "pr_lim");
        set_free(2'd0, 2'd0, 2'd0, 3'b111); cycle(0, "pr_after");

        // Hole in fetch group truncates acceptance
        set_fetch(3'b101, 32'h300, 3'b000); cycle(0, "v101");
        set_fetch(3'b000, 32'h0, 3'b000);   cycle(0, "v101_after");

        // Drain, then WFI in slot 1
        set_free(2'd3, 2'd3, 2'd3, 3'b111);
        cycle(3, "drain0");
        cycle(3, "drain1");
        set_fetch(3'b111, 32'h400, 3'b010); cycle(1, "wfi_enq");
        set_fetch(3'b000, 32'h0, 3'b000);   cycle(2, "wfi_disp");
        set_fetch(3'b111, 32'h500, 3'b000); cycle(0, "halt_enq0");
        set_fetch(3'b111, 32'h50C, 3'b000); cycle(0, "halt_enq1");
        set_fetch(3'b111, 32'h518, 3'b000); cycle(0, "halt_enq2");
        set_fetch(3'b000, 32'h0, 3'b000);   cycle(0, "halt_full");
        squash = 1'b1;
        set_fetch(3'b111, 32'h600, 3'b000); cycle(0, "sq_halt");
        squash = 1'b0;

        // Squash with six entries and full downstream room
        set_free(2'd0, 2'd0, 2'd0, 3'b111);
        set_fetch(3'b111, 32'h700, 3'b000); cycle(0, "pre_sq0");
        set_fetch(3'b111, 32'h70C, 3'b000); cycle(0, "pre_sq1");
        set_free(2'd3, 2'd3, 2'd3, 3'b111);
        squash = 1'b1;
        set_fetch(3'b111, 32'h800, 3'b000); cycle(0, "squash6");
        squash = 1'b0;
        set_fetch(3'b000, 32'h0, 3'b000);   cycle(0, "post_sq");

        // Walk head to 7, then dispatch across the wrap
        set_fetch(3'b111, 32'h900, 3'b000); cycle(0, "w1");
        set_fetch(3'b111, 32'h90C, 3'b000); cycle(3, "w2");
        set_fetch(3'b111, 32'h918, 3'b000); cycle(3, "w3");
        set_fetch(3'b000, 32'h0, 3'b000);
        set_free(2'd1, 2'd3, 2'd3, 3'b111); cycle(1, "w4");
        set_free(2'd3, 2'd3, 2'd3, 3'b111); cycle(2, "w5");
        cycle(0, "end");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
